dct_2d_sequencer: RTL

Controller that sequences the 2D DCT datapath: first 1D DCT, ping-pong transpose buffer, second 1D DCT. It accepts an 8x8 block pixel stream under a valid/ready handshake and drives the stage enables. It also drives the transpose-buffer write/read bank selects and produces output framing (valid, start-of-block, end-of-block). It sits between the pixel source and the 2D DCT datapath and replaces fixed start-up counting with per-sample, per-block tracking.

---
 rtl/dct_2d_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dct_2d_sequencer.sv
// dct_2d_sequencer: sequencing control for a two-stage (row/column) 2D DCT.
// Accepts an 8x8 pixel stream on a valid/ready handshake. It also:
//   - drives the stage-1 and stage-2 1D DCT enables;
//   - drives the ping-pong transpose-buffer write/read controls;
//   - frames the coefficient output with valid/sop/eop.
// Optional feature macro: DCT_SEQ_STATS_EN adds a 16-bit completed-block counter
// on output port blk_count.
// Handshake: a sample transfers in every cycle where in_valid && in_ready.
// in_ready does not depend on in_valid. The output side has no backpressure.
module dct_2d_sequencer #(
    parameter int DCT_LATENCY = 48,
    parameter int BLK_SAMPLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        dct1_ena,
    output logic        trb_wr_en,
    output logic        trb_wr_bank,
    output logic        trb_rd_en,
    output logic        trb_rd_bank,
    output logic        dct2_ena,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
`ifdef DCT_SEQ_STATS_EN
    output logic [15:0] blk_count,
`endif
    output logic        busy
);

    localparam int CW = $clog2(BLK_SAMPLES);
    localparam logic [CW-1:0] LAST = CW'(BLK_SAMPLES - 1);

    typedef enum logic {RD_IDLE = 1'b0, RD_ACTIVE = 1'b1} rd_state_e;

    rd_state_e              rd_state_q, rd_state_d;
    logic [CW-1:0]          in_cnt_q, in_cnt_d;
    logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic [1:0]             credit_q, credit_d;
    logic [1:0]             full_q, full_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [DCT_LATENCY-1:0] d1_sr_q, d1_sr_d;
    logic [DCT_LATENCY-1:0] d2_sr_q, d2_sr_d;
    logic [DCT_LATENCY-1:0] sop_sr_q, sop_sr_d;
    logic [DCT_LATENCY-1:0] eop_sr_q, eop_sr_d;
    logic                   wr_done, rd_done, credit_inc;
    logic [1:0]             full_set, full_clr, full_now;

    // Input handshake, writer, reader FSM, credit and delay lines.
    always_comb begin
        // in_ready is forced low while reset is held so all outputs read 0.
        in_ready   = rst && ((in_cnt_q != '0) || (credit_q < 2'd2));
        dct1_ena   = in_valid && in_ready;
        in_cnt_d   = in_cnt_q;
        if (dct1_ena) begin
            in_cnt_d = (in_cnt_q == LAST) ? '0 : in_cnt_q + 1'b1;
        end
        credit_inc = dct1_ena && (in_cnt_q == '0);

        // Stage-1 latency model: a write happens DCT_LATENCY cycles after acceptance.
        d1_sr_d     = {d1_sr_q[DCT_LATENCY-2:0], dct1_ena};
        trb_wr_en   = d1_sr_q[DCT_LATENCY-1];
        trb_wr_bank = wr_bank_q;
        wr_done     = trb_wr_en && (wr_cnt_q == LAST);
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        if (trb_wr_en) begin
            wr_cnt_d = (wr_cnt_q == LAST) ? '0 : wr_cnt_q + 1'b1;
        end
        if (wr_done) begin
            wr_bank_d = ~wr_bank_q;
        end
        full_set = wr_done ? (2'b01 << wr_bank_q) : 2'b00;
        // Bypass view so the reader can start in the cycle after the last write.
        full_now = full_q | full_set;

        trb_rd_en   = (rd_state_q == RD_ACTIVE);
        trb_rd_bank = rd_bank_q;
        dct2_ena    = trb_rd_en;
        rd_done     = trb_rd_en && (rd_cnt_q == LAST);
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        full_clr    = 2'b00;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_now[rd_bank_q]) begin
                    rd_state_d = RD_ACTIVE;
                end
            end
            RD_ACTIVE: begin
                rd_cnt_d = (rd_cnt_q == LAST) ? '0 : rd_cnt_q + 1'b1;
                if (rd_done) begin
                    full_clr  = 2'b01 << rd_bank_q;
                    rd_bank_d = ~rd_bank_q;
                    // Continue straight into the other bank when it is ready.
                    if (!full_now[~rd_bank_q]) begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        full_d = (full_q & ~full_clr) | full_set;

        credit_d = credit_q;
        if (credit_inc && !rd_done) begin
            credit_d = credit_q + 2'd1;
        end else if (!credit_inc && rd_done) begin
            credit_d = credit_q - 2'd1;
        end

        // Stage-2 latency model with framing carried alongside.
        d2_sr_d  = {d2_sr_q[DCT_LATENCY-2:0], dct2_ena};
        sop_sr_d = {sop_sr_q[DCT_LATENCY-2:0], dct2_ena && (rd_cnt_q == '0)};
        eop_sr_d = {eop_sr_q[DCT_LATENCY-2:0], dct2_ena && (rd_cnt_q == LAST)};
        out_valid = d2_sr_q[DCT_LATENCY-1];
        out_sop   = sop_sr_q[DCT_LATENCY-1];
        out_eop   = eop_sr_q[DCT_LATENCY-1];

        busy = (credit_q != 2'd0) || (|d1_sr_q) || (|d2_sr_q) || trb_rd_en;
    end

    // State registers; asynchronous reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= RD_IDLE;
            in_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            credit_q   <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            d1_sr_q    <= '0;
            d2_sr_q    <= '0;
            sop_sr_q   <= '0;
            eop_sr_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            in_cnt_q   <= in_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            credit_q   <= credit_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            d1_sr_q    <= d1_sr_d;
            d2_sr_q    <= d2_sr_d;
            sop_sr_q   <= sop_sr_d;
            eop_sr_q   <= eop_sr_d;
        end
    end

`ifdef DCT_SEQ_STATS_EN
    logic [15:0] blk_count_q, blk_count_d;

    // Completed-block counter, wraps naturally at 16 bits.
    always_comb begin
        blk_count_d = blk_count_q;
        if (out_valid && out_eop) begin
            blk_count_d = blk_count_q + 16'd1;
        end
        blk_count = blk_count_q;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_count_q <= '0;
        end else begin
            blk_count_q <= blk_count_d;
        end
    end
`endif

endmodule
